framebuffer_arbiter: RTL
========================

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter WIDTH, default 160: framebuffer width in pixels.
REQ-002 Parameter HEIGHT, default 120: framebuffer height in pixels.
REQ-003 Parameter PIX_W, default 8: pixel width in bits.
REQ-004 Parameter ADDR_W, default 15: memory address width; SHALL satisfy 2^ADDR_W >= WIDTH*HEIGHT.
REQ-005 Parameter FIFO_DEPTH, default 4: write FIFO depth; power of two, at least 2.
REQ-006 CLOCK_25  in  1: sole clock; all logic on its rising edge.
REQ-007 reset  in  1: synchronous, active-high.
REQ-008 disp_x  in  10, disp_y  in  9: scan-out pixel coordinate from the video driver.
REQ-009 disp_active  in  1: scan-out is inside the active read window.
REQ-010 pixel_out  out  PIX_W: registered pixel for the coordinate presented 2 cycles earlier.
REQ-011 wr_valid  in  1, wr_ready  out  1: write-request handshake; transfer occurs when both are high on a rising edge.
REQ-012 wr_x  in  10, wr_y  in  9, wr_data  in  PIX_W: write coordinate and pixel, sampled on transfer.
REQ-013 mem_addr  out  ADDR_W, mem_we  out  1, mem_wdata  out  PIX_W: registered single-port RAM command.
REQ-014 mem_rdata  in  PIX_W: RAM read data, valid 1 cycle after the read command.
REQ-015 fifo_count  out  clog2(FIFO_DEPTH)+1: current write-FIFO occupancy.

Function
REQ-016 One RAM command SHALL issue per cycle: a display read, a write, or an idle read of address 0 with mem_we=0.
REQ-017 Address SHALL be y*WIDTH+x, computed at full width, then truncated to ADDR_W.
REQ-018 A display read SHALL issue when disp_active=1 and either (disp_x,disp_y) differs from the last read coordinate or the last-coordinate register is invalid.
REQ-019 Display reads SHALL have absolute priority; a write SHALL pop the FIFO only in cycles with no display read.
REQ-020 Display coordinate with x>=WIDTH or y>=HEIGHT: no read issued; pixel_out SHALL be 0 two cycles later.
REQ-021 Display latency: coordinate sampled at edge t, mem_addr valid after t, pixel_out updated at t+2. pixel_out SHALL hold its value while the coordinate is unchanged.
REQ-022 disp_active falling SHALL invalidate the last-coordinate register, so the first active cycle of each line issues a read.
REQ-023 wr_ready SHALL equal (fifo_count < FIFO_DEPTH) and SHALL be 0 while reset is asserted.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged. Push when full is impossible because wr_ready=0.
REQ-025 FIFO order SHALL be preserved; writes SHALL never be reordered or merged.
REQ-026 A write and a display read to the same address in the same cycle: the read wins; the write executes later; the display sees old data.

Reset
REQ-027 On reset the block SHALL:
- set fifo_count to 0 and discard queued writes;
- invalidate the last-coordinate register;
- set pixel_out, mem_addr, mem_wdata and mem_we to 0.
REQ-028 Reset mid-transfer SHALL drop the in-flight write without a partial RAM write.

Configuration
REQ-029 Macro FB_BOUNDS_CHECK_EN defined: a write with wr_x>=WIDTH or wr_y>=HEIGHT SHALL be accepted (wr_ready honoured), not queued, and never reach the RAM.
REQ-030 Macro FB_BOUNDS_CHECK_EN undefined: every accepted write SHALL be queued and issued with the truncated address of REQ-017.

Verification
REQ-031 Reset, then idle with disp_active=0 -> wr_ready=1, fifo_count=0, mem_we=0, pixel_out=0.
REQ-032 disp_active=1, x steps 0..3 every 4 cycles, y=0 -> exactly one read per new x at addr 0,1,2,3; pixel_out = mem_rdata 2 cycles after each step.
REQ-033 Push 5 writes back-to-back with disp_active=1 and x changing every cycle -> wr_ready drops after 4; no mem_we; fifo_count=4.
REQ-034 Then disp_active=0 -> 4 writes issue in order on consecutive cycles; write (3,2,0xA5) appears as mem_addr=323, mem_wdata=0xA5; 5th write is then accepted.
REQ-035 With FB_BOUNDS_CHECK_EN, write (160,0) -> accepted, no mem_we. Without the macro -> mem_we with mem_addr=160.
REQ-036 Assert reset with fifo_count=3 -> next cycle fifo_count=0; no mem_we after reset releases.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares one single-port RAM between display scan-out reads and queued pixel writes.
// Latency: RAM command registered one cycle after sampling; pixel_out two cycles after the coordinate is sampled.
// Backpressure: wr_ready low while the write FIFO is full or reset is high; display reads always win, writes drain in gaps.
// Optional feature macro FB_BOUNDS_CHECK_EN: out-of-range writes are accepted and dropped instead of wrapping.
module framebuffer_arbiter #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_25,
    input  logic                          reset,
    input  logic [9:0]                    disp_x,
    input  logic [8:0]                    disp_y,
    input  logic                          disp_active,
    output logic [PIX_W-1:0]              pixel_out,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [9:0]                    wr_x,
    input  logic [8:0]                    wr_y,
    input  logic [PIX_W-1:0]              wr_data,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_we,
    output logic [PIX_W-1:0]              mem_wdata,
    input  logic [PIX_W-1:0]              mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_entry_t;

    wr_entry_t         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              last_vld;
    logic [9:0]        last_x;
    logic [8:0]        last_y;

    logic              rd_s1;
    logic              rd_s2;
    logic              oob_s1;
    logic              oob_s2;

    logic              disp_in_bounds;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_read;
    logic              disp_oob;
    logic [ADDR_W-1:0] wr_addr;
    logic              push;
    logic              pop;
    wr_entry_t         head;

    assign fifo_count = count;
    assign head       = fifo_mem[rd_ptr];

    // Read/write arbitration, address generation and FIFO handshake decode.
    always_comb begin
        disp_in_bounds = ({22'd0, disp_x} < 32'(WIDTH)) && ({23'd0, disp_y} < 32'(HEIGHT));
        disp_addr      = ADDR_W'({23'd0, disp_y} * 32'(WIDTH) + {22'd0, disp_x});
        disp_read      = disp_active && disp_in_bounds &&
                         (!last_vld || (disp_x != last_x) || (disp_y != last_y));
        disp_oob       = disp_active && !disp_in_bounds;
        wr_addr        = ADDR_W'({23'd0, wr_y} * 32'(WIDTH) + {22'd0, wr_x});
        wr_ready       = !reset && (count < DEPTH_C);
`ifdef FB_BOUNDS_CHECK_EN
        // Out-of-range writes complete the handshake but never enter the queue.
        push           = wr_valid && wr_ready &&
                         ({22'd0, wr_x} < 32'(WIDTH)) && ({23'd0, wr_y} < 32'(HEIGHT));
`else
        push           = wr_valid && wr_ready;
`endif
        pop            = !disp_read && (count != '0);
    end

    // FIFO storage; only written on an accepted push, which cannot happen in reset.
    always_ff @(posedge CLOCK_25) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: wr_addr, data: wr_data};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered RAM command: display read, else queued write, else idle read of address 0.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (disp_read) begin
            mem_addr  <= disp_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (pop) begin
            mem_addr  <= head.addr;
            mem_we    <= 1'b1;
            mem_wdata <= head.data;
        end else begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end
    end

    // Last-read coordinate; cleared when blanking or off-screen so the next valid pixel re-reads.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            last_vld <= 1'b0;
            last_x   <= '0;
            last_y   <= '0;
        end else if (!disp_active || !disp_in_bounds) begin
            last_vld <= 1'b0;
        end else if (disp_read) begin
            last_vld <= 1'b1;
            last_x   <= disp_x;
            last_y   <= disp_y;
        end
    end

    // Two-stage tracking of read/off-screen events so pixel_out lines up with RAM read data.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            rd_s1     <= 1'b0;
            rd_s2     <= 1'b0;
            oob_s1    <= 1'b0;
            oob_s2    <= 1'b0;
            pixel_out <= '0;
        end else begin
            rd_s1  <= disp_read;
            rd_s2  <= rd_s1;
            oob_s1 <= disp_oob;
            oob_s2 <= oob_s1;
            if (rd_s2) begin
                pixel_out <= mem_rdata;
            end else if (oob_s2) begin
                pixel_out <= '0;
            end
        end
    end

endmodule
